// File: rtl/mode_counter_pkg.sv
// -----------------------------------------------------------------------------
// mode_counter_pkg
//   Shared types and constants for the mode_counter block.
//   - cnt_state_t : control FSM states (idle / running / one-shot finished)
//   - CNT_UP / CNT_DOWN : encoding of the latched count direction
//   - ps_width()  : register width for a 0..n-1 counter, never below 1 bit
// -----------------------------------------------------------------------------
package mode_counter_pkg;

    typedef enum logic [1:0] {
        CNT_IDLE = 2'd0,
        CNT_RUN  = 2'd1,
        CNT_DONE = 2'd2
    } cnt_state_t;

    localparam logic CNT_UP   = 1'b0;
    localparam logic CNT_DOWN = 1'b1;

    // Width of a counter that must hold values 0..n-1 (1 bit minimum so a
    // divide-by-1 prescaler still has a legal register).
    function automatic int unsigned ps_width(input int unsigned n);
        return (n > 32'd1) ? $clog2(n) : 32'd1;
    endfunction

endpackage

// File: rtl/mode_counter_if.sv
// -----------------------------------------------------------------------------
// mode_counter_if
//   Control/status bundle of mode_counter. Clock and reset stay plain ports
//   on the counter itself.
//   Parameter: CNT_W - width of the count and load-value buses.
//   Signals:
//     i_start    start/restart pulse        i_stop     abort to idle
//     i_en       step enable (pause when 0) i_dir      0 up / 1 down (at start)
//     i_load     parallel load strobe       i_load_val load value
//     o_cnt      current count              o_tc       terminal-count pulse
//     o_done     one-shot finished (level)  o_busy     counter running
//   Modports: master drives the controls, slave is the counter.
// -----------------------------------------------------------------------------
interface mode_counter_if #(
    parameter int CNT_W = 5
);
    logic             i_start;
    logic             i_stop;
    logic             i_en;
    logic             i_dir;
    logic             i_load;
    logic [CNT_W-1:0] i_load_val;
    logic [CNT_W-1:0] o_cnt;
    logic             o_tc;
    logic             o_done;
    logic             o_busy;

    modport master (
        output i_start, i_stop, i_en, i_dir, i_load, i_load_val,
        input  o_cnt, o_tc, o_done, o_busy
    );

    modport slave (
        input  i_start, i_stop, i_en, i_dir, i_load, i_load_val,
        output o_cnt, o_tc, o_done, o_busy
    );
endinterface

// File: rtl/mode_counter_prescaler.sv
// -----------------------------------------------------------------------------
// cnt_prescaler
//   Divides enabled cycles by PRESCALE. The internal counter walks
//   0..PRESCALE-1 on every cycle with i_en high and holds while i_en is low.
//   o_tick is high on an enabled cycle in which the counter sits at
//   PRESCALE-1, i.e. once every PRESCALE enabled cycles.
//   Parameter: PRESCALE - enabled cycles per tick (>= 1)
//   Ports:
//     i_clk  clock
//     i_rst  asynchronous active-high reset
//     i_clr  synchronous clear (wins over i_en)
//     i_en   count enable
//     o_tick step qualifier for the parent counter
// -----------------------------------------------------------------------------
module cnt_prescaler
    import mode_counter_pkg::*;
#(
    parameter int PRESCALE = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tick
);
    localparam int unsigned        PS_W    = ps_width(PRESCALE);
    localparam logic [PS_W-1:0]    PS_LAST = PS_W'(PRESCALE - 1);
    localparam logic [PS_W-1:0]    PS_ONE  = PS_W'(1);

    logic [PS_W-1:0] ps_r;
    logic            at_last_s;

    assign at_last_s = (ps_r == PS_LAST);

    // Enabled-cycle counter with clear priority and wrap at PRESCALE-1
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ps_r <= '0;
        end else if (i_clr) begin
            ps_r <= '0;
        end else if (i_en) begin
            if (at_last_s) begin
                ps_r <= '0;
            end else begin
                ps_r <= ps_r + PS_ONE;
            end
        end else begin
            ps_r <= ps_r;
        end
    end

    assign o_tick = i_en & at_last_s;

endmodule

// File: rtl/mode_counter.sv
// -----------------------------------------------------------------------------
// mode_counter
//   Parametrised up/down event counter with start/stop, loop or one-shot
//   operation, parallel load and a registered terminal-count pulse.
//   Parameters:
//     MAX_CNT  count modulus, values 0..MAX_CNT-1 (>= 2)
//     LOOP     1 = wrap at terminal and keep running, 0 = one-shot
//     CNT_W    count width, 2**CNT_W >= MAX_CNT
//     PRESCALE enabled cycles per step when CNT_PRESCALE_EN is defined
//   Build option:
//     CNT_PRESCALE_EN - when defined, a cnt_prescaler gates every step so the
//     count moves once per PRESCALE enabled RUN cycles; otherwise the count
//     moves on every enabled RUN cycle.
//   Ports:
//     i_clk  clock
//     i_rst  asynchronous active-high reset
//     bus    mode_counter_if.slave (controls in, o_cnt/o_tc/o_done/o_busy out)
//   Per-cycle priority: stop > load > start > step.
// -----------------------------------------------------------------------------
module mode_counter
    import mode_counter_pkg::*;
#(
    parameter int   MAX_CNT  = 32,
    parameter logic LOOP     = 1'b1,
    parameter int   CNT_W    = $clog2(MAX_CNT),
    parameter int   PRESCALE = 4
) (
    input  logic          i_clk,
    input  logic          i_rst,
    mode_counter_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_MAX_V = CNT_W'(MAX_CNT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE_V = CNT_W'(1);

    // Elaboration-time parameter sanity checks
    if (MAX_CNT < 2) begin : g_bad_max_cnt
        $error("mode_counter: MAX_CNT must be at least 2");
    end
    if ((2 ** CNT_W) < MAX_CNT) begin : g_bad_cnt_w
        $error("mode_counter: CNT_W too narrow for MAX_CNT");
    end
    if (PRESCALE < 1) begin : g_bad_prescale
        $error("mode_counter: PRESCALE must be at least 1");
    end

    cnt_state_t       state_r;
    cnt_state_t       state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             dir_r;
    logic             dir_nxt_s;
    logic             tc_r;
    logic             tc_nxt_s;
    logic             busy_r;
    logic             done_r;

    logic             tick_s;
    logic             step_s;
    logic             at_term_s;
    logic [CNT_W-1:0] restart_val_s;
    logic [CNT_W-1:0] load_clamp_s;

`ifdef CNT_PRESCALE_EN
    logic ps_clr_s;

    // Any control event or leaving RUN restarts the step interval from zero.
    assign ps_clr_s = bus.i_stop | bus.i_load | bus.i_start | (state_r != CNT_RUN);

    cnt_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_clr  (ps_clr_s),
        .i_en   (bus.i_en),
        .o_tick (tick_s)
    );
`else
    assign tick_s = 1'b1;
`endif

    // Terminal and restart values follow the direction latched at start.
    assign at_term_s     = (dir_r == CNT_DOWN) ? (cnt_r == '0) : (cnt_r == CNT_MAX_V);
    assign restart_val_s = (dir_r == CNT_DOWN) ? CNT_MAX_V : '0;
    assign load_clamp_s  = (bus.i_load_val > CNT_MAX_V) ? CNT_MAX_V : bus.i_load_val;
    assign step_s        = (state_r == CNT_RUN) & bus.i_en & tick_s;

    // Next state, next count, direction latch and terminal pulse, in priority order
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        dir_nxt_s   = dir_r;
        tc_nxt_s    = 1'b0;

        if (bus.i_stop) begin
            state_nxt_s = CNT_IDLE;
            cnt_nxt_s   = '0;
        end else if (bus.i_load) begin
            cnt_nxt_s = load_clamp_s;
            // A load revives a finished one-shot; idle and running keep their state.
            if (state_r == CNT_DONE) begin
                state_nxt_s = CNT_RUN;
            end else begin
                state_nxt_s = state_r;
            end
        end else if (bus.i_start) begin
            dir_nxt_s   = bus.i_dir;
            cnt_nxt_s   = (bus.i_dir == CNT_DOWN) ? CNT_MAX_V : '0;
            state_nxt_s = CNT_RUN;
        end else if (step_s) begin
            if (at_term_s) begin
                tc_nxt_s = 1'b1;
                if (LOOP) begin
                    cnt_nxt_s = restart_val_s;
                end else begin
                    cnt_nxt_s   = cnt_r;
                    state_nxt_s = CNT_DONE;
                end
            end else if (dir_r == CNT_DOWN) begin
                cnt_nxt_s = cnt_r - CNT_ONE_V;
            end else begin
                cnt_nxt_s = cnt_r + CNT_ONE_V;
            end
        end else begin
            state_nxt_s = state_r;
        end

        // An unreachable state encoding falls back to a clean idle.
        case (state_r)
            CNT_IDLE, CNT_RUN, CNT_DONE: begin
                dir_nxt_s = dir_nxt_s;
            end
            default: begin
                state_nxt_s = CNT_IDLE;
                cnt_nxt_s   = '0;
                tc_nxt_s    = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers; busy/done registered from next state
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r <= CNT_IDLE;
            cnt_r   <= '0;
            dir_r   <= CNT_UP;
            tc_r    <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            dir_r   <= dir_nxt_s;
            tc_r    <= tc_nxt_s;
            busy_r  <= (state_nxt_s == CNT_RUN);
            done_r  <= (state_nxt_s == CNT_DONE);
        end
    end

    assign bus.o_cnt  = cnt_r;
    assign bus.o_tc   = tc_r;
    assign bus.o_busy = busy_r;
    assign bus.o_done = done_r;

endmodule

// File: tb/tb_mode_counter.sv
// -----------------------------------------------------------------------------
// tb_mode_counter
//   Two counters (LOOP=1 and LOOP=0, MAX_CNT=5, PRESCALE=3) driven with the
//   same controls. A reference model built from the counting rules predicts
//   each cycle's outputs into per-DUT queues; a monitor pops and compares one
//   step after every active clock edge.
// -----------------------------------------------------------------------------
module tb_mode_counter;
    localparam int MAX_CNT  = 5;
    localparam int CNT_W    = 3;
    localparam int PRESCALE = 3;
`ifdef CNT_PRESCALE_EN
    localparam bit PS_ON = 1'b1;
`else
    localparam bit PS_ON = 1'b0;
`endif

    typedef struct packed {
        logic [CNT_W-1:0] cnt;
        logic             tc;
        logic             done;
        logic             busy;
    } obs_t;

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;

    int n_tests = 0;
    int n_fail  = 0;

    mode_counter_if #(.CNT_W(CNT_W)) bus_loop ();
    mode_counter_if #(.CNT_W(CNT_W)) bus_shot ();

    mode_counter #(.MAX_CNT(MAX_CNT), .LOOP(1'b1), .CNT_W(CNT_W), .PRESCALE(PRESCALE)) u_loop (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus_loop)
    );

    mode_counter #(.MAX_CNT(MAX_CNT), .LOOP(1'b0), .CNT_W(CNT_W), .PRESCALE(PRESCALE)) u_shot (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus_shot)
    );

    always #5 i_clk = ~i_clk;

    // Reference model: index 0 = looping counter, index 1 = one-shot counter
    int   m_cnt  [2];
    bit   m_run  [2];
    bit   m_done [2];
    bit   m_down [2];
    bit   m_tc   [2];
    int   m_ps   [2];
    bit   m_loop [2] = '{1'b1, 1'b0};
    obs_t exp_q  [2][$];

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_cnt[k] = 0; m_run[k] = 0; m_done[k] = 0;
            m_down[k] = 0; m_tc[k] = 0; m_ps[k] = 0;
        end
    endfunction

    function automatic void model_step(input int k, input bit start, input bit stop,
                                       input bit en, input bit dir, input bit load, input int lv);
        bit stepping;
        int first;
        int last;
        m_tc[k] = 1'b0;
        if (stop) begin
            m_cnt[k] = 0; m_run[k] = 0; m_done[k] = 0; m_ps[k] = 0;
        end else if (load) begin
            m_cnt[k] = (lv > MAX_CNT - 1) ? MAX_CNT - 1 : lv;
            if (m_done[k]) m_run[k] = 1'b1;
            m_done[k] = 1'b0;
            m_ps[k]   = 0;
        end else if (start) begin
            m_down[k] = dir;
            m_cnt[k]  = dir ? MAX_CNT - 1 : 0;
            m_run[k]  = 1'b1;
            m_done[k] = 1'b0;
            m_ps[k]   = 0;
        end else if (m_run[k] && en) begin
            if (PS_ON) begin
                stepping = (m_ps[k] == PRESCALE - 1);
                m_ps[k]  = (m_ps[k] + 1) % PRESCALE;
            end else begin
                stepping = 1'b1;
            end
            if (stepping) begin
                first = m_down[k] ? MAX_CNT - 1 : 0;
                last  = m_down[k] ? 0 : MAX_CNT - 1;
                if (m_cnt[k] == last) begin
                    m_tc[k] = 1'b1;
                    if (m_loop[k]) begin
                        m_cnt[k] = first;
                    end else begin
                        m_run[k]  = 1'b0;
                        m_done[k] = 1'b1;
                    end
                end else begin
                    m_cnt[k] = (m_cnt[k] + (m_down[k] ? MAX_CNT - 1 : 1)) % MAX_CNT;
                end
            end
        end
        if (!m_run[k]) m_ps[k] = 0;
    endfunction

    function automatic obs_t model_obs(input int k);
        obs_t o;
        o.cnt  = CNT_W'(m_cnt[k]);
        o.tc   = m_tc[k];
        o.done = m_done[k];
        o.busy = m_run[k];
        return o;
    endfunction

    function automatic obs_t dut_obs(input int k);
        obs_t o;
        if (k == 0) begin
            o.cnt = bus_loop.o_cnt; o.tc = bus_loop.o_tc;
            o.done = bus_loop.o_done; o.busy = bus_loop.o_busy;
        end else begin
            o.cnt = bus_shot.o_cnt; o.tc = bus_shot.o_tc;
            o.done = bus_shot.o_done; o.busy = bus_shot.o_busy;
        end
        return o;
    endfunction

    task automatic check(input string name, input obs_t got, input obs_t want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s @%0t: got cnt=%0d tc=%b done=%b busy=%b, required cnt=%0d tc=%b done=%b busy=%b",
                     name, $time, got.cnt, got.tc, got.done, got.busy,
                     want.cnt, want.tc, want.done, want.busy);
        end
    endtask

    // Drive one cycle of controls (applied at the next rising edge) and queue predictions
    task automatic cyc(input bit start, input bit stop, input bit en, input bit dir,
                       input bit load, input int lv);
        bus_loop.i_start = start; bus_shot.i_start = start;
        bus_loop.i_stop  = stop;  bus_shot.i_stop  = stop;
        bus_loop.i_en    = en;    bus_shot.i_en    = en;
        bus_loop.i_dir   = dir;   bus_shot.i_dir   = dir;
        bus_loop.i_load  = load;  bus_shot.i_load  = load;
        bus_loop.i_load_val = CNT_W'(lv);
        bus_shot.i_load_val = CNT_W'(lv);
        for (int k = 0; k < 2; k++) begin
            model_step(k, start, stop, en, dir, load, lv);
            exp_q[k].push_back(model_obs(k));
        end
        @(negedge i_clk);
    endtask

    task automatic run_en(input int n, input bit dir);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b1, dir, 1'b0, 0);
    endtask

    task automatic reset_cycle();
        model_reset();
        for (int k = 0; k < 2; k++) exp_q[k].push_back(model_obs(k));
        @(negedge i_clk);
    endtask

    // Monitor: compare each DUT against its oldest prediction just after the edge
    initial begin
        obs_t want;
        forever begin
            @(posedge i_clk);
            #1;
            for (int k = 0; k < 2; k++) begin
                if (exp_q[k].size() > 0) begin
                    want = exp_q[k].pop_front();
                    check((k == 0) ? "loop_cnt" : "shot_cnt", dut_obs(k), want);
                end
            end
        end
    end

    // Stimulus: directed scenarios, then randomized traffic
    initial begin
        obs_t zero_o;
        bit   r_start, r_stop, r_load, r_en, r_dir;
        int   r_lv;
        zero_o = '0;
        bus_loop.i_start = 1'b0; bus_loop.i_stop = 1'b0; bus_loop.i_en = 1'b0;
        bus_loop.i_dir = 1'b0; bus_loop.i_load = 1'b0; bus_loop.i_load_val = '0;
        bus_shot.i_start = 1'b0; bus_shot.i_stop = 1'b0; bus_shot.i_en = 1'b0;
        bus_shot.i_dir = 1'b0; bus_shot.i_load = 1'b0; bus_shot.i_load_val = '0;
        model_reset();
        @(negedge i_clk);
        reset_cycle();
        reset_cycle();
        i_rst = 1'b0;

        // Up count with wrap (loop) / finish (one-shot)
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        run_en(14, 1'b0);
        // Down count
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0);
        run_en(10, 1'b0);
        // Pause at 2 while toggling dir, then resume
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        run_en(2 * (PS_ON ? PRESCALE : 1), 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, i[0], 1'b0, 0);
        run_en(3, 1'b1);
        // Load above range in RUN clamps without tc, then run to terminal
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 7);
        run_en(2 * (PS_ON ? PRESCALE : 1), 1'b0);
        // Load 1 while the one-shot is finished
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1);
        run_en(3, 1'b0);
        // Terminal value loaded: no tc from the load itself
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4);
        // Load in IDLE after stop, and simultaneous stop+load+start
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2);
        run_en(2, 1'b0);
        // Reset asserted between edges mid-run: outputs clear at once
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        run_en(3, 1'b0);
        #2;
        i_rst = 1'b1;
        #1;
        check("async_rst_loop", dut_obs(0), zero_o);
        check("async_rst_shot", dut_obs(1), zero_o);
        @(negedge i_clk);
        reset_cycle();
        i_rst = 1'b0;

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            r_start = ($urandom_range(15) == 0);
            r_stop  = ($urandom_range(40) == 0);
            r_load  = ($urandom_range(18) == 0);
            r_en    = ($urandom_range(3) != 0);
            r_dir   = $urandom_range(1) == 1;
            r_lv    = $urandom_range(7);
            cyc(r_start, r_stop, r_en, r_dir, r_load, r_lv);
        end

        @(posedge i_clk);
        #2;
        n_tests++;
        if (exp_q[0].size() != 0 || exp_q[1].size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain: %0d/%0d predictions left, required 0/0",
                     exp_q[0].size(), exp_q[1].size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
